// File: rtl/tqvp_cordic_rotator.sv
// tqvp_cordic_rotator: TinyQV peripheral rotating (X,Y) by angle Z with a one-iteration-per-cycle CORDIC.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales results by 1/1.6468.
module tqvp_cordic_rotator #(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);
  typedef enum logic [1:0] {IDLE, PRE, ROT, GAIN} state_t;
  localparam logic signed [15:0] atan_lut [16] = '{
    16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297, 16'sd651, 16'sd326, 16'sd163, 16'sd81,
    16'sd41, 16'sd20, 16'sd10, 16'sd5, 16'sd3, 16'sd1, 16'sd1, 16'sd0};
  state_t state, state_nx;
  logic [15:0] x_in, y_in, z_in;
  logic signed [17:0] x, y, x_r, y_r, x_f, y_f, x_res, y_res;
  logic signed [15:0] z, z_r, z_f, z_res;
  logic [3:0] step;
  logic done, irq_en, busy, wr, start, last, fin;
  logic [31:0] rd_data;
  logic unused;
  assign unused = ^{ui_in, data_in};
  assign busy = state != IDLE;
  assign wr = data_write_n != 2'b11;
  assign start = wr && address == 6'h00 && data_in[0] && !busy;
  assign last = step == 4'(ITER - 1);
  assign uo_out = {6'b0, done, busy};
  assign user_interrupt = done & irq_en;
  function automatic logic [15:0] merge(input logic [15:0] cur);
    return data_write_n == 2'b00 ? {cur[15:8], data_in[7:0]} : data_in[15:0];
  endfunction
  always_comb begin
    x_r = z[15] ? x + (y >>> step) : x - (y >>> step);
    y_r = z[15] ? y - (x >>> step) : y + (x >>> step);
    z_r = z[15] ? z + atan_lut[step] : z - atan_lut[step];
  end
`ifdef CORDIC_GAIN_COMP_EN
  localparam state_t after_rot = GAIN;
  localparam logic signed [17:0] gain_k = 18'sd19898;
  logic signed [35:0] px, py;
  assign px = x * gain_k;
  assign py = y * gain_k;
  assign fin = state == GAIN;
  assign x_f = 18'(px >>> 15);
  assign y_f = 18'(py >>> 15);
  assign z_f = z;
`else
  localparam state_t after_rot = IDLE;
  assign fin = state == ROT && last;
  assign x_f = x_r;
  assign y_f = y_r;
  assign z_f = z_r;
`endif
  always_comb begin
    state_nx = state == IDLE ? (start ? PRE : IDLE) :
               state == PRE  ? ROT :
               state == ROT  ? (last ? after_rot : ROT) : IDLE;
  end
  always_comb begin
    rd_data = address == 6'h00 ? {28'b0, irq_en, done, busy, 1'b0} :
              address == 6'h04 ? {16'b0, x_in} :
              address == 6'h08 ? {16'b0, y_in} :
              address == 6'h0C ? {16'b0, z_in} :
              address == 6'h10 ? {{14{x_res[17]}}, x_res} :
              address == 6'h14 ? {{14{y_res[17]}}, y_res} :
              address == 6'h18 ? {{16{z_res[15]}}, z_res} : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      {x_in, y_in, z_in} <= '0;
      {x, y, z, step} <= '0;
      {x_res, y_res, z_res} <= '0;
      {done, irq_en} <= '0;
      data_out <= '0;
      data_ready <= 1'b0;
    end else begin
      state <= state_nx;
      data_ready <= data_read_n != 2'b11;
      if (data_read_n != 2'b11) data_out <= rd_data;
      if (wr && address == 6'h00) begin
        irq_en <= data_in[3];
        if (data_in[2]) done <= 1'b0;
      end
      if (wr && !busy && address == 6'h04) x_in <= merge(x_in);
      if (wr && !busy && address == 6'h08) y_in <= merge(y_in);
      if (wr && !busy && address == 6'h0C) z_in <= merge(z_in);
      if (start) begin
        done <= 1'b0;
        x <= {{2{x_in[15]}}, x_in};
        y <= {{2{y_in[15]}}, y_in};
        z <= z_in;
        step <= '0;
      end
      // Fold quadrants II/III into I/IV so the rotation range stays within the atan sum.
      if (state == PRE) begin
        x <= z[15:14] == 2'b01 ? -y : z[15:14] == 2'b10 ? y : x;
        y <= z[15:14] == 2'b01 ? x : z[15:14] == 2'b10 ? -x : y;
        z <= z[15:14] == 2'b01 ? z - 16'sh4000 : z[15:14] == 2'b10 ? z + 16'sh4000 : z;
      end
      if (state == ROT) begin
        x <= x_r;
        y <= y_r;
        z <= z_r;
        step <= step + 4'd1;
      end
      if (fin) begin
        x_res <= x_f;
        y_res <= y_f;
        z_res <= z_f;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tqvp_cordic_rotator.sv
// tb_tqvp_cordic_rotator: directed register-level checks of the CORDIC rotator peripheral.
module tb_tqvp_cordic_rotator;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 19;
  localparam int K45 = 5793;
  localparam int K180 = -8192;
`else
  localparam int LAT = 18;
  localparam int K45 = 9539;
  localparam int K180 = -13491;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uo_out;
  logic [5:0] address = '0;
  logic [31:0] data_in = '0;
  logic [1:0] data_write_n = 2'b11;
  logic [1:0] data_read_n = 2'b11;
  logic [31:0] data_out;
  logic data_ready;
  logic user_interrupt;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] v;

  tqvp_cordic_rotator dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol = 0);
    int d;
    n_cmp++;
    d = $signed(got) - $signed(exp);
    if (d < -tol || d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h) tol %0d", tag, $signed(got), got, $signed(exp), exp, tol);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w = 2'b10);
    address = a;
    data_in = d;
    data_write_n = w;
    @(posedge clk);
    #1 data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] r);
    address = a;
    data_read_n = 2'b10;
    @(posedge clk);
    #1 data_read_n = 2'b11;
    r = data_out;
    check("data_ready", {31'b0, data_ready}, 32'd1);
  endtask

  task automatic run(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] zi, input logic [31:0] ctrl);
    wr(6'h04, {16'b0, xi});
    wr(6'h08, {16'b0, yi});
    wr(6'h0C, {16'b0, zi});
    wr(6'h00, ctrl);
    repeat (LAT - 2) @(posedge clk);
    #1;
    check("busy_before_done", {24'b0, uo_out}, 32'h1);
    check("irq_before_done", {31'b0, user_interrupt}, 32'd0);
    @(posedge clk);
    #1;
    check("done_at_latency", {24'b0, uo_out}, 32'h2);
    check("irq_with_done", {31'b0, user_interrupt}, {31'b0, ctrl[3]});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_uo_out", {24'b0, uo_out}, 32'h0);
    check("reset_irq", {31'b0, user_interrupt}, 32'h0);
    check("reset_ready", {31'b0, data_ready}, 32'h0);
    check("reset_data_out", data_out, 32'h0);
    for (int a = 0; a <= 6'h18; a += 4) begin
      rd(6'(a), v);
      check($sformatf("reset_reg_%02h", a), v, 32'h0);
    end

    wr(6'h04, 32'h0000_1234, 2'b01);
    wr(6'h04, 32'hFFFF_FFAB, 2'b00);
    rd(6'h04, v);
    check("byte_write_merge", v, 32'h0000_12AB);
    wr(6'h1C, 32'hFFFF_FFFF);
    rd(6'h1C, v);
    check("unmapped_read", v, 32'h0);

    run(16'd8192, 16'd0, 16'h2000, 32'h1);
    rd(6'h10, v);
    check("x_out_45", v, K45, 4);
    rd(6'h14, v);
    check("y_out_45", v, K45, 4);
    rd(6'h18, v);
    check("z_res_45", v, 32'h0, 2);
    rd(6'h00, v);
    check("status_done", v, 32'h4);
    @(posedge clk);
    #1;
    check("ready_single_pulse", {31'b0, data_ready}, 32'h0);
    check("data_out_holds", data_out, 32'h4);

    run(16'd8192, 16'd0, 16'h8000, 32'h1);
    rd(6'h10, v);
    check("x_out_180", v, K180, 4);
    rd(6'h14, v);
    check("y_out_180", v, 32'h0, 4);
    rd(6'h18, v);
    check("z_res_180", v, 32'h0, 2);

    run(16'd8192, 16'd0, 16'h2000, 32'h9);
    wr(6'h00, 32'hC);
    check("clear_done_uo", {24'b0, uo_out}, 32'h0);
    check("clear_done_irq", {31'b0, user_interrupt}, 32'h0);
    rd(6'h00, v);
    check("status_irq_en_only", v, 32'h8);

    wr(6'h04, 32'd8192);
    wr(6'h08, 32'd0);
    wr(6'h0C, 32'h2000);
    wr(6'h00, 32'h1);
    wr(6'h04, 32'h1234);
    wr(6'h00, 32'h1);
    repeat (LAT - 4) @(posedge clk);
    #1;
    check("restart_busy", {24'b0, uo_out}, 32'h1);
    @(posedge clk);
    #1;
    check("restart_done_time", {24'b0, uo_out}, 32'h2);
    rd(6'h10, v);
    check("restart_x_out", v, K45, 4);
    rd(6'h04, v);
    check("busy_write_ignored", v, 32'd8192);

    wr(6'h00, 32'h9);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_uo_out", {24'b0, uo_out}, 32'h0);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    check("abort_stays_idle", {24'b0, uo_out}, 32'h0);
    check("abort_no_irq", {31'b0, user_interrupt}, 32'h0);
    rd(6'h10, v);
    check("abort_x_out", v, 32'h0);
    rd(6'h14, v);
    check("abort_y_out", v, 32'h0);
    rd(6'h00, v);
    check("abort_status", v, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
